// File: rtl/nco_sweep_ctrl.sv
// NCO tuning-word sweep sequencer: start word + signed step, per-word dwell, one-shot or continuous.
// Optional build macro NCO_SWEEP_PINGPONG_EN turns the sweep around at each end instead of wrapping.
module nco_sweep_ctrl #(
  parameter int PHASE_W = 24,
  parameter int DWELL_W = 20,
  parameter int STEPS_W = 8
) (
  input  logic               pll_clock,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic               continuous,
  input  logic [PHASE_W-1:0] cfg_start_word,
  input  logic [PHASE_W-1:0] cfg_step,
  input  logic [STEPS_W-1:0] cfg_num_steps,
  input  logic [DWELL_W-1:0] cfg_dwell,
  output logic [PHASE_W-1:0] tw,
  output logic               tw_valid,
  input  logic               tw_ready,
  output logic [STEPS_W-1:0] step_idx,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DWELL, S_DONE} state_t;

  state_t state, state_d;

  logic [PHASE_W-1:0] start_word_q, start_word_d;
  logic [PHASE_W-1:0] step_q, step_d;
  logic [STEPS_W-1:0] last_idx_q, last_idx_d;
  logic [DWELL_W-1:0] dwell_ld_q, dwell_ld_d;
  logic               cont_q, cont_d;
  logic [PHASE_W-1:0] tw_q, tw_d;
  logic [STEPS_W-1:0] idx_q, idx_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
`ifdef NCO_SWEEP_PINGPONG_EN
  logic               dir_q, dir_d;   // 1 = walking back toward idx 0
`endif

  logic xfer, at_top;
`ifdef NCO_SWEEP_PINGPONG_EN
  logic at_bot;
  assign at_bot = (idx_q == '0);
`endif

  assign xfer   = (state == S_LOAD) && tw_ready;
  assign at_top = (idx_q == last_idx_q);

  always_comb begin
    state_d      = state;
    start_word_d = start_word_q;
    step_d       = step_q;
    last_idx_d   = last_idx_q;
    dwell_ld_d   = dwell_ld_q;
    cont_d       = cont_q;
    tw_d         = tw_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
`ifdef NCO_SWEEP_PINGPONG_EN
    dir_d        = dir_q;
`endif
    case (state)
      S_IDLE: begin
        if (start && !abort) begin
          start_word_d = cfg_start_word;
          step_d       = cfg_step;
          // Store N-1 and dwell-1 so zero configs collapse to one word / one cycle.
          last_idx_d   = (cfg_num_steps == '0) ? '0 : cfg_num_steps - STEPS_W'(1);
          dwell_ld_d   = (cfg_dwell == '0) ? '0 : cfg_dwell - DWELL_W'(1);
          cont_d       = continuous;
          tw_d         = cfg_start_word;
          idx_d        = '0;
`ifdef NCO_SWEEP_PINGPONG_EN
          dir_d        = 1'b0;
`endif
          state_d      = S_LOAD;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          cnt_d   = dwell_ld_q;
          state_d = S_DWELL;
        end
      end
      S_DWELL: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - DWELL_W'(1);
        end else begin
`ifdef NCO_SWEEP_PINGPONG_EN
          if (!dir_q) begin
            if (!at_top) begin
              tw_d    = tw_q + step_q;
              idx_d   = idx_q + STEPS_W'(1);
              state_d = S_LOAD;
            end else if (last_idx_q == '0) begin
              if (cont_q) begin
                tw_d    = start_word_q;
                idx_d   = '0;
                state_d = S_LOAD;
              end else begin
                state_d = S_DONE;
              end
            end else begin
              dir_d   = 1'b1;
              tw_d    = tw_q - step_q;
              idx_d   = idx_q - STEPS_W'(1);
              state_d = S_LOAD;
            end
          end else begin
            if (!at_bot) begin
              tw_d    = tw_q - step_q;
              idx_d   = idx_q - STEPS_W'(1);
              state_d = S_LOAD;
            end else if (cont_q) begin
              dir_d   = 1'b0;
              tw_d    = tw_q + step_q;
              idx_d   = idx_q + STEPS_W'(1);
              state_d = S_LOAD;
            end else begin
              state_d = S_DONE;
            end
          end
`else
          if (!at_top) begin
            tw_d    = tw_q + step_q;
            idx_d   = idx_q + STEPS_W'(1);
            state_d = S_LOAD;
          end else if (cont_q) begin
            tw_d    = start_word_q;
            idx_d   = '0;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
`endif
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort beats everything; a simultaneous transfer has already happened on the wire.
    if (abort && state != S_IDLE) state_d = S_IDLE;
  end

  always_ff @(posedge pll_clock) begin
    if (reset) begin
      state        <= S_IDLE;
      start_word_q <= '0;
      step_q       <= '0;
      last_idx_q   <= '0;
      dwell_ld_q   <= '0;
      cont_q       <= 1'b0;
      tw_q         <= '0;
      idx_q        <= '0;
      cnt_q        <= '0;
`ifdef NCO_SWEEP_PINGPONG_EN
      dir_q        <= 1'b0;
`endif
    end else begin
      state        <= state_d;
      start_word_q <= start_word_d;
      step_q       <= step_d;
      last_idx_q   <= last_idx_d;
      dwell_ld_q   <= dwell_ld_d;
      cont_q       <= cont_d;
      tw_q         <= tw_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
`ifdef NCO_SWEEP_PINGPONG_EN
      dir_q        <= dir_d;
`endif
    end
  end

  assign tw       = tw_q;
  assign step_idx = idx_q;
  assign tw_valid = (state == S_LOAD);
  assign busy     = (state != S_IDLE);
  assign done     = (state == S_DONE);

endmodule
